// File: rtl/polymul_negacyclic_pkg.sv
// Shared types and helpers for the negacyclic polynomial multiplier.
// Covers FSM states, the ternary u encoding and the counter sizing.
package polymul_pkg;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    OUTPUT
  } state_e;

  localparam logic [1:0] U_ZERO = 2'b00;
  localparam logic [1:0] U_POS  = 2'b01;
  localparam logic [1:0] U_NEG  = 2'b11;
  localparam logic [1:0] U_RSVD = 2'b10;

  typedef struct packed {
    logic nz;
    logic neg;
  } udec_t;

  // The reserved ternary code 2'b10 decodes as zero.
  function automatic udec_t u_decode(input logic [1:0] i_u, input bit i_signed);
    udec_t d;
    d.nz  = 1'b0;
    d.neg = 1'b0;
    if (!i_signed) begin
      d.nz = i_u[0];
    end else begin
      case (i_u)
        U_POS: d.nz = 1'b1;
        U_NEG: begin
          d.nz  = 1'b1;
          d.neg = 1'b1;
        end
        default: d.nz = 1'b0;
      endcase
    end
    return d;
  endfunction

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/polymul_negacyclic_if.sv
// AXI-stream style channel: valid/ready handshake with last and data.
interface axis_if #(
  parameter int W = 8
);
  logic         vld;
  logic         rdy;
  logic         last;
  logic [W-1:0] data;

  modport master (output vld, output last, output data, input rdy);
  modport slave  (input vld, input last, input data, output rdy);
endinterface

// File: rtl/polymul_negacyclic_mod_addsub.sv
// Combinational a+b or a-b reduced mod Q; both operands must already be below Q.
module mod_addsub #(
  parameter int QW = 5,
  parameter int Q  = 29
) (
  input  logic [QW-1:0] i_a,
  input  logic [QW-1:0] i_b,
  input  logic          i_sub,
  output logic [QW-1:0] o_y
);

  localparam logic [QW:0] QV = (QW+1)'(Q);

  logic [QW:0] w_sum;
  logic [QW:0] w_diff;
  logic [QW:0] w_res;

  always_comb begin
    w_sum  = {1'b0, i_a} + {1'b0, i_b};
    w_diff = {1'b0, i_a} - {1'b0, i_b};
    w_res  = '0;
    if (i_sub) begin
      w_res = w_diff[QW] ? (w_diff + QV) : w_diff;
    end else begin
      w_res = (w_sum >= QV) ? (w_sum - QV) : w_sum;
    end
  end

  assign o_y = w_res[QW-1:0];

endmodule

// File: rtl/polymul_negacyclic.sv
// Streaming z = p*u mod (x^N+1, Q): load N paired beats, accumulate one p
// coefficient per cycle into all N lanes, then stream the N results out.
module polymul_negacyclic
  import polymul_pkg::*;
#(
  parameter int N        = 4,
  parameter int QW       = 5,
  parameter int Q        = 29,
  parameter int UW       = 2,
  parameter int U_SIGNED = 1
) (
  input  logic  clk,
  input  logic  s_rst_n,
  axis_if.slave  p,
  axis_if.slave  u,
  axis_if.master z,
  output logic  err,
  output logic  busy
);

  localparam int            CW      = cnt_width(N);
  localparam logic [CW-1:0] LASTIDX = CW'(N - 1);
  localparam logic [QW:0]   QV      = (QW+1)'(Q);

  state_e        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_oidx;
  logic [QW-1:0] r_pbuf [N];
  logic [UW-1:0] r_ubuf [N];
  logic [QW-1:0] r_acc  [N];
  logic [QW-1:0] w_accNext [N];
  logic          r_err;
  logic          w_inRdy;
  logic          w_zvld;
  logic          w_zlast;
  logic [QW-1:0] w_zdata;
  logic          w_frameErr;

  always_comb begin
    w_next  = r_state;
    w_inRdy = 1'b0;
    w_zvld  = 1'b0;
    w_zlast = 1'b0;
    w_zdata = '0;
    case (r_state)
      LOAD: begin
        w_inRdy = p.vld && u.vld;
        if (w_inRdy && (r_cnt == LASTIDX)) w_next = COMPUTE;
      end
      COMPUTE: begin
        if (r_cnt == LASTIDX) w_next = OUTPUT;
      end
      OUTPUT: begin
        w_zvld  = 1'b1;
        w_zdata = r_acc[r_oidx];
        w_zlast = (r_oidx == LASTIDX);
        if (z.rdy && w_zlast) w_next = LOAD;
      end
      default: w_next = LOAD;
    endcase
  end

  assign p.rdy  = w_inRdy;
  assign u.rdy  = w_inRdy;
  assign z.vld  = w_zvld;
  assign z.last = w_zlast;
  assign z.data = w_zdata;
  assign err    = r_err;
  assign busy   = (r_state != LOAD);

  // The beat counter decides framing; last flags and range are only checked.
  assign w_frameErr = (p.last != (r_cnt == LASTIDX)) ||
                      (u.last != (r_cnt == LASTIDX)) ||
                      ({1'b0, p.data} >= QV);

  // Lane k takes p[i]*u[k-i]; wrapped terms (k < i) are negated by x^N = -1.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [CW-1:0] w_j;
    udec_t         w_dec;
    logic [QW-1:0] w_t;
    logic          w_sub;

    assign w_j   = CW'(k) - r_cnt;
    assign w_dec = u_decode(2'(r_ubuf[w_j]), U_SIGNED != 0);
    assign w_t   = w_dec.nz ? r_pbuf[r_cnt] : '0;
    assign w_sub = (CW'(k) < r_cnt) ^ w_dec.neg;

    mod_addsub #(.QW(QW), .Q(Q)) u_addsub (
      .i_a   (r_acc[k]),
      .i_b   (w_t),
      .i_sub (w_sub),
      .o_y   (w_accNext[k])
    );
  end

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state <= LOAD;
      r_cnt   <= '0;
      r_oidx  <= '0;
      r_err   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_acc[k]  <= '0;
        r_pbuf[k] <= '0;
        r_ubuf[k] <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        LOAD: begin
          if (w_inRdy) begin
            r_pbuf[r_cnt] <= p.data;
            r_ubuf[r_cnt] <= u.data;
            if (w_frameErr) r_err <= 1'b1;
            if (r_cnt == LASTIDX) begin
              r_cnt <= '0;
              for (int k = 0; k < N; k++) r_acc[k] <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          for (int k = 0; k < N; k++) r_acc[k] <= w_accNext[k];
          if (r_cnt == LASTIDX) begin
            r_cnt  <= '0;
            r_oidx <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (z.rdy) r_oidx <= (r_oidx == LASTIDX) ? '0 : r_oidx + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_polymul_negacyclic.sv
// Directed bench for polymul_negacyclic (N=4, Q=29) with a ternary and a binary instance.
module tb_polymul_negacyclic;

  logic clk = 1'b0;
  logic s_rst_n;
  logic errA, busyA, errB, busyB;
  int   testsRun  = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  axis_if #(.W(5)) pa ();
  axis_if #(.W(2)) ua ();
  axis_if #(.W(5)) za ();
  axis_if #(.W(5)) pb ();
  axis_if #(.W(1)) ub ();
  axis_if #(.W(5)) zb ();

  // The binary instance sees the same beats with u reduced to its low bit.
  assign pb.vld  = pa.vld;
  assign pb.last = pa.last;
  assign pb.data = pa.data;
  assign ub.vld  = ua.vld;
  assign ub.last = ua.last;
  assign ub.data = ua.data[0];
  assign zb.rdy  = za.rdy;

  polymul_negacyclic #(.N(4), .QW(5), .Q(29), .UW(2), .U_SIGNED(1)) dutA (
    .clk(clk), .s_rst_n(s_rst_n), .p(pa), .u(ua), .z(za), .err(errA), .busy(busyA)
  );

  polymul_negacyclic #(.N(4), .QW(5), .Q(29), .UW(1), .U_SIGNED(0)) dutB (
    .clk(clk), .s_rst_n(s_rst_n), .p(pb), .u(ub), .z(zb), .err(errB), .busy(busyB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    testsRun++;
    failCount++;
    $error("[TB] FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [19:0] pv, input logic [7:0] uv,
                               input int lastAt, input bit expectImmediate);
    for (int i = 0; i < 4; i++) begin
      int w;
      pa.data = pv[i*5 +: 5];
      ua.data = uv[i*2 +: 2];
      pa.last = (i == lastAt);
      ua.last = (i == 3);
      pa.vld  = 1'b1;
      ua.vld  = 1'b1;
      #1;
      if (i == 0 && expectImmediate) checkOutput("rdy_after_last_hs", pa.rdy, 1);
      w = 0;
      while (pa.rdy !== 1'b1 && w < 100) begin
        tick();
        w++;
      end
      if (w >= 100) timeoutFail("load_timeout");
      tick();
    end
    pa.vld  = 1'b0;
    ua.vld  = 1'b0;
    pa.last = 1'b0;
    ua.last = 1'b0;
  endtask

  task automatic checkLatency();
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput("zvld_in_compute", za.vld, 0);
      checkOutput("busy_in_compute", busyA, 1);
      pa.vld = 1'b1;
      ua.vld = 1'b1;
      #1;
      checkOutput("rdy_in_compute", pa.rdy, 0);
      pa.vld = 1'b0;
      ua.vld = 1'b0;
    end
    tick();
    checkOutput("zvld_latency", za.vld, 1);
  endtask

  task automatic recvFrame(input logic [19:0] zexp, input bit hold, input bit checkB);
    for (int i = 0; i < 4; i++) begin
      int w;
      w = 0;
      while (za.vld !== 1'b1 && w < 100) begin
        tick();
        w++;
      end
      if (w >= 100) timeoutFail("z_timeout");
      checkOutput("z_data", za.data, zexp[i*5 +: 5]);
      checkOutput("z_last", za.last, (i == 3) ? 1 : 0);
      if (checkB) checkOutput("zb_data", zb.data, zexp[i*5 +: 5]);
      if (hold && (i % 2 == 1)) begin
        for (int h = 0; h < 2; h++) begin
          tick();
          checkOutput("z_hold_data", za.data, zexp[i*5 +: 5]);
          checkOutput("z_hold_vld", za.vld, 1);
          checkOutput("rdy_in_output", pa.rdy, 0);
        end
      end
      za.rdy = 1'b1;
      tick();
      za.rdy = 1'b0;
    end
    checkOutput("zvld_after_frame", za.vld, 0);
    checkOutput("busy_after_frame", busyA, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pa.vld = 1'b0; pa.last = 1'b0; pa.data = '0;
    ua.vld = 1'b0; ua.last = 1'b0; ua.data = '0;
    za.rdy = 1'b0;
    s_rst_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_zvld", za.vld, 0);
    checkOutput("rst_zlast", za.last, 0);
    checkOutput("rst_zdata", za.data, 0);
    checkOutput("rst_err", errA, 0);
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_prdy", pa.rdy, 0);
    s_rst_n = 1'b1;
    tick();

    // 1: all +1 ternary, and binary instance with u=1
    applyStimulus({5'd4, 5'd3, 5'd2, 5'd1}, 8'h55, 3, 1'b0);
    checkLatency();
    recvFrame({5'd10, 5'd2, 5'd25, 5'd21}, 1'b0, 1'b1);
    checkOutput("err_clean", errA, 0);
    checkOutput("errB_clean", errB, 0);

    // 2: identity
    applyStimulus({5'd27, 5'd26, 5'd25, 5'd24}, 8'h01, 3, 1'b0);
    checkLatency();
    recvFrame({5'd27, 5'd26, 5'd25, 5'd24}, 1'b0, 1'b1);

    // 3: multiply by x
    applyStimulus({5'd8, 5'd7, 5'd6, 5'd5}, 8'h04, 3, 1'b0);
    checkLatency();
    recvFrame({5'd7, 5'd6, 5'd5, 5'd21}, 1'b0, 1'b1);

    // 4: all -1
    applyStimulus({5'd4, 5'd3, 5'd2, 5'd1}, 8'hFF, 3, 1'b0);
    checkLatency();
    recvFrame({5'd19, 5'd27, 5'd4, 5'd8}, 1'b0, 1'b0);

    // 5: backpressure then back-to-back frame
    applyStimulus({5'd4, 5'd3, 5'd2, 5'd1}, 8'h55, 3, 1'b0);
    checkLatency();
    recvFrame({5'd10, 5'd2, 5'd25, 5'd21}, 1'b1, 1'b0);
    applyStimulus({5'd8, 5'd7, 5'd6, 5'd5}, 8'h04, 3, 1'b1);
    checkLatency();
    recvFrame({5'd7, 5'd6, 5'd5, 5'd21}, 1'b0, 1'b0);

    pa.vld = 1'b1;
    pa.data = 5'd3;
    ua.vld = 1'b0;
    #1;
    checkOutput("p_only_rdy", pa.rdy, 0);
    tick();
    tick();
    checkOutput("p_only_busy", busyA, 0);
    pa.vld = 1'b0;
    applyStimulus({5'd27, 5'd26, 5'd25, 5'd24}, 8'h01, 3, 1'b0);
    checkLatency();
    recvFrame({5'd27, 5'd26, 5'd25, 5'd24}, 1'b0, 1'b0);
    checkOutput("err_still_clean", errA, 0);

    // 6a: early p.last
    applyStimulus({5'd4, 5'd3, 5'd2, 5'd1}, 8'h55, 1, 1'b0);
    checkLatency();
    checkOutput("err_early_last", errA, 1);
    recvFrame({5'd10, 5'd2, 5'd25, 5'd21}, 1'b0, 1'b0);
    checkOutput("err_sticky", errA, 1);
    s_rst_n = 1'b0;
    #1;
    checkOutput("err_cleared", errA, 0);
    s_rst_n = 1'b1;
    tick();

    // 6b: out-of-range p stored unchanged: 30 + 0 mod 29 = 1
    applyStimulus({5'd0, 5'd0, 5'd0, 5'd30}, 8'h01, 3, 1'b0);
    checkLatency();
    checkOutput("err_range", errA, 1);
    recvFrame({5'd0, 5'd0, 5'd0, 5'd1}, 1'b0, 1'b0);

    // 6c: reset during COMPUTE
    applyStimulus({5'd4, 5'd3, 5'd2, 5'd1}, 8'h55, 3, 1'b0);
    tick();
    tick();
    checkOutput("busy_before_abort", busyA, 1);
    s_rst_n = 1'b0;
    #1;
    checkOutput("abort_zvld", za.vld, 0);
    checkOutput("abort_err", errA, 0);
    checkOutput("abort_busy", busyA, 0);
    tick();
    s_rst_n = 1'b1;
    tick();
    applyStimulus({5'd4, 5'd3, 5'd2, 5'd1}, 8'hFF, 3, 1'b0);
    checkLatency();
    recvFrame({5'd19, 5'd27, 5'd4, 5'd8}, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
